// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external 32-bit ALU between two requesters
// and captures each result into a one-entry response register per port.
module alu_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic [3:0]  req0_op_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  input  logic [3:0]  req1_op_i,
  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic [31:0] rsp0_res_o,
  output logic        rsp0_zf_o,
  output logic        rsp0_sign_o,
  output logic        rsp0_err_o,
  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic [31:0] rsp1_res_o,
  output logic        rsp1_zf_o,
  output logic        rsp1_sign_o,
  output logic        rsp1_err_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [3:0]  alu_op_o,
  input  logic [31:0] alu_res_i,
  input  logic        alu_zf_i,
  input  logic        alu_sign_i
);

  typedef enum logic {PRIO0, PRIO1} prio_e;

  prio_e state_q, state_d;
  logic  slot0_free, slot1_free;
  logic  elig0, elig1;
  logic  grant0, grant1;
  logic  op_illegal;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= PRIO0;
    else       state_q <= state_d;
  end

  // A slot being drained this cycle can accept a new result on the same edge.
  always_comb begin
    slot0_free = !rsp0_valid_o | rsp0_ready_i;
    slot1_free = !rsp1_valid_o | rsp1_ready_i;
    elig0      = req0_valid_i & slot0_free;
    elig1      = req1_valid_i & slot1_free;
    grant0     = elig0 & (!elig1 | (state_q == PRIO0));
    grant1     = elig1 & !grant0;

    state_d = state_q;
    if (grant0)      state_d = PRIO1;
    else if (grant1) state_d = PRIO0;

    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_op_o = '0;
    if (grant0) begin
      alu_a_o  = req0_a_i;
      alu_b_o  = req0_b_i;
      alu_op_o = req0_op_i;
    end else if (grant1) begin
      alu_a_o  = req1_a_i;
      alu_b_o  = req1_b_i;
      alu_op_o = req1_op_i;
    end
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  always_comb begin
    op_illegal = 1'b1;
    case (alu_op_o)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b0110, 4'b0111,
      4'b1001, 4'b1100: op_illegal = 1'b0;
      default:          op_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp0_valid_o <= 1'b0;
      rsp0_res_o   <= '0;
      rsp0_zf_o    <= 1'b0;
      rsp0_sign_o  <= 1'b0;
      rsp0_err_o   <= 1'b0;
    end else if (grant0) begin
      rsp0_valid_o <= 1'b1;
      rsp0_res_o   <= alu_res_i;
      rsp0_zf_o    <= alu_zf_i;
      rsp0_sign_o  <= alu_sign_i;
      rsp0_err_o   <= op_illegal;
    end else if (rsp0_ready_i & rsp0_valid_o) begin
      rsp0_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp1_valid_o <= 1'b0;
      rsp1_res_o   <= '0;
      rsp1_zf_o    <= 1'b0;
      rsp1_sign_o  <= 1'b0;
      rsp1_err_o   <= 1'b0;
    end else if (grant1) begin
      rsp1_valid_o <= 1'b1;
      rsp1_res_o   <= alu_res_i;
      rsp1_zf_o    <= alu_zf_i;
      rsp1_sign_o  <= alu_sign_i;
      rsp1_err_o   <= op_illegal;
    end else if (rsp1_ready_i & rsp1_valid_o) begin
      rsp1_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: per-cycle vector table plus hand-written
// reset sequences, with a small behavioural ALU answering the DUT's requests.
module tb_alu_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req1_valid_i;
  logic        req0_ready_o, req1_ready_o;
  logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
  logic [3:0]  req0_op_i, req1_op_i;
  logic        rsp0_valid_o, rsp1_valid_o;
  logic        rsp0_ready_i, rsp1_ready_i;
  logic [31:0] rsp0_res_o, rsp1_res_o;
  logic        rsp0_zf_o, rsp1_zf_o, rsp0_sign_o, rsp1_sign_o, rsp0_err_o, rsp1_err_o;
  logic [31:0] alu_a_o, alu_b_o;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_res_i;
  logic        alu_zf_i, alu_sign_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  alu_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_op_i(req0_op_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_op_i(req1_op_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
    .rsp0_res_o(rsp0_res_o), .rsp0_zf_o(rsp0_zf_o), .rsp0_sign_o(rsp0_sign_o), .rsp0_err_o(rsp0_err_o),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
    .rsp1_res_o(rsp1_res_o), .rsp1_zf_o(rsp1_zf_o), .rsp1_sign_o(rsp1_sign_o), .rsp1_err_o(rsp1_err_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .alu_res_i(alu_res_i), .alu_zf_i(alu_zf_i), .alu_sign_i(alu_sign_i)
  );

  // External ALU: illegal ops return 0 with zf set.
  logic [63:0] rot;
  always_comb begin
    rot = {alu_b_o, alu_b_o} >> alu_a_o[4:0];
    case (alu_op_o)
      4'b0000: alu_res_i = alu_a_o & alu_b_o;
      4'b0001: alu_res_i = alu_a_o | alu_b_o;
      4'b0010: alu_res_i = alu_a_o + alu_b_o;
      4'b0011: alu_res_i = alu_a_o ^ alu_b_o;
      4'b0100: alu_res_i = alu_b_o << alu_a_o[4:0];
      4'b0101: alu_res_i = alu_b_o >> alu_a_o[4:0];
      4'b0110: alu_res_i = alu_a_o - alu_b_o;
      4'b0111: alu_res_i = {31'd0, $signed(alu_a_o) < $signed(alu_b_o)};
      4'b1001: alu_res_i = rot[31:0];
      4'b1100: alu_res_i = ~(alu_a_o | alu_b_o);
      default: alu_res_i = '0;
    endcase
    alu_zf_i   = (alu_res_i == '0);
    alu_sign_i = alu_res_i[31];
  end

  typedef struct {
    logic        v0, v1, rr0, rr1;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  op0, op1;
    logic        x_rdy0, x_rdy1;
    logic [3:0]  x_aop;
    logic        x_v0, x_zf0, x_s0, x_e0;
    logic [31:0] x_res0;
    logic        x_v1, x_zf1, x_s1, x_e1;
    logic [31:0] x_res1;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(
    input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] op0,
    input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] op1,
    input logic rr0, input logic rr1,
    input logic x_rdy0, input logic x_rdy1, input logic [3:0] x_aop,
    input logic x_v0, input logic [31:0] x_res0, input logic x_zf0, input logic x_s0, input logic x_e0,
    input logic x_v1, input logic [31:0] x_res1, input logic x_zf1, input logic x_s1, input logic x_e1);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.b0 = b0; v.op0 = op0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.op1 = op1;
    v.rr0 = rr0; v.rr1 = rr1;
    v.x_rdy0 = x_rdy0; v.x_rdy1 = x_rdy1; v.x_aop = x_aop;
    v.x_v0 = x_v0; v.x_res0 = x_res0; v.x_zf0 = x_zf0; v.x_s0 = x_s0; v.x_e0 = x_e0;
    v.x_v1 = x_v1; v.x_res1 = x_res1; v.x_zf1 = x_zf1; v.x_s1 = x_s1; v.x_e1 = x_e1;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic v1, input logic rr0, input logic rr1);
    req0_valid_i = v0; req1_valid_i = v1;
    rsp0_ready_i = rr0; rsp1_ready_i = rr1;
  endtask

  initial begin
    rst_i = 1'b1;
    drive(0, 0, 0, 0);
    req0_a_i = '0; req0_b_i = '0; req0_op_i = '0;
    req1_a_i = '0; req1_b_i = '0; req1_op_i = '0;

    //      v0 a0       b0     op0    v1 a1 b1 op1    rr0 rr1 rdy0 rdy1 aop  | rsp0: v res zf s e | rsp1: v res zf s e
    add_vec(1, 5,       7,     4'h2,  0, 0, 0, 4'h0,  1, 1,  1, 0, 4'h2,  1, 32'd12,        0, 0, 0,  0, 0,             0, 0, 0);
    add_vec(1, 10,      20,    4'h2,  1, 3, 5, 4'h6,  1, 1,  0, 1, 4'h6,  0, 32'd12,        0, 0, 0,  1, 32'hFFFFFFFE,  0, 1, 0);
    add_vec(1, 10,      20,    4'h2,  1, 3, 5, 4'h6,  1, 1,  1, 0, 4'h2,  1, 32'd30,        0, 0, 0,  0, 32'hFFFFFFFE,  0, 1, 0);
    add_vec(1, 10,      20,    4'h2,  1, 3, 5, 4'h6,  1, 1,  0, 1, 4'h6,  0, 32'd30,        0, 0, 0,  1, 32'hFFFFFFFE,  0, 1, 0);
    add_vec(1, 10,      20,    4'h2,  1, 3, 5, 4'h6,  1, 1,  1, 0, 4'h2,  1, 32'd30,        0, 0, 0,  0, 32'hFFFFFFFE,  0, 1, 0);
    // rsp0 full and held: port 1 wins twice, including while the state favours port 0
    add_vec(1, 10,      20,    4'h2,  1, 7, 2, 4'h0,  0, 1,  0, 1, 4'h0,  1, 32'd30,        0, 0, 0,  1, 32'd2,         0, 0, 0);
    add_vec(1, 10,      20,    4'h2,  1, 7, 2, 4'h0,  0, 1,  0, 1, 4'h0,  1, 32'd30,        0, 0, 0,  1, 32'd2,         0, 0, 0);
    add_vec(1, 100,     1,     4'h2,  1, 7, 2, 4'h0,  1, 1,  1, 0, 4'h2,  1, 32'd101,       0, 0, 0,  0, 32'd2,         0, 0, 0);
    add_vec(0, 0,       0,     4'h0,  1, 1, 1, 4'hF,  1, 1,  0, 1, 4'hF,  0, 32'd101,       0, 0, 0,  1, 32'd0,         1, 0, 1);
    add_vec(1, 4,       32'hF, 4'h9,  0, 0, 0, 4'h0,  1, 1,  1, 0, 4'h9,  1, 32'hF0000000,  0, 1, 0,  0, 32'd0,         1, 0, 1);
    add_vec(0, 0,       0,     4'h0,  1, 0, 9, 4'h4,  1, 1,  0, 1, 4'h4,  0, 32'hF0000000,  0, 1, 0,  1, 32'd9,         0, 0, 0);
    add_vec(0, 0,       0,     4'h0,  0, 0, 0, 4'h0,  1, 1,  0, 0, 4'h0,  0, 32'hF0000000,  0, 1, 0,  0, 32'd9,         0, 0, 0);
    add_vec(1, 0,       0,     4'hC,  0, 0, 0, 4'h0,  1, 1,  1, 0, 4'hC,  1, 32'hFFFFFFFF,  0, 1, 0,  0, 32'd9,         0, 0, 0);
    add_vec(1, 2,       3,     4'h8,  0, 0, 0, 4'h0,  1, 1,  1, 0, 4'h8,  1, 32'd0,         1, 0, 1,  0, 32'd9,         0, 0, 0);

    #12;
    chk("reset rsp0_valid", rsp0_valid_o, 0);
    chk("reset rsp1_valid", rsp1_valid_o, 0);
    chk("reset rsp0_res", rsp0_res_o, 0);
    chk("reset rsp1 flags", {rsp1_zf_o, rsp1_sign_o, rsp1_err_o}, 0);
    chk("reset alu_op", alu_op_o, 0);
    chk("reset readies", {req0_ready_o, req1_ready_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk_i);
      req0_a_i = vecs[i].a0; req0_b_i = vecs[i].b0; req0_op_i = vecs[i].op0;
      req1_a_i = vecs[i].a1; req1_b_i = vecs[i].b1; req1_op_i = vecs[i].op1;
      drive(vecs[i].v0, vecs[i].v1, vecs[i].rr0, vecs[i].rr1);
      #1;
      chk($sformatf("v%0d req0_ready", i), req0_ready_o, vecs[i].x_rdy0);
      chk($sformatf("v%0d req1_ready", i), req1_ready_o, vecs[i].x_rdy1);
      chk($sformatf("v%0d alu_op", i), alu_op_o, vecs[i].x_aop);
      @(posedge clk_i);
      #1;
      chk($sformatf("v%0d rsp0_valid", i), rsp0_valid_o, vecs[i].x_v0);
      chk($sformatf("v%0d rsp1_valid", i), rsp1_valid_o, vecs[i].x_v1);
      if (vecs[i].x_v0) begin
        chk($sformatf("v%0d rsp0_res", i), rsp0_res_o, vecs[i].x_res0);
        chk($sformatf("v%0d rsp0 zf/sign/err", i), {rsp0_zf_o, rsp0_sign_o, rsp0_err_o},
            {vecs[i].x_zf0, vecs[i].x_s0, vecs[i].x_e0});
      end
      if (vecs[i].x_v1) begin
        chk($sformatf("v%0d rsp1_res", i), rsp1_res_o, vecs[i].x_res1);
        chk($sformatf("v%0d rsp1 zf/sign/err", i), {rsp1_zf_o, rsp1_sign_o, rsp1_err_o},
            {vecs[i].x_zf1, vecs[i].x_s1, vecs[i].x_e1});
      end
    end

    // Mid-traffic reset: fill rsp0 (state moves to PRIO1), then reset between edges.
    @(negedge clk_i);
    req0_a_i = 1; req0_b_i = 1; req0_op_i = 4'h2;
    req1_a_i = 2; req1_b_i = 2; req1_op_i = 4'h2;
    drive(1, 0, 0, 0);
    @(posedge clk_i);
    #1;
    chk("pre-reset rsp0_valid", rsp0_valid_o, 1);
    drive(0, 0, 0, 0);
    #2;
    rst_i = 1'b1;
    #1;
    chk("async reset rsp0_valid", rsp0_valid_o, 0);
    chk("async reset rsp1_valid", rsp1_valid_o, 0);
    chk("async reset rsp0_res", rsp0_res_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(1, 1, 1, 1);
    #1;
    chk("post-reset req0_ready", req0_ready_o, 1);
    chk("post-reset req1_ready", req1_ready_o, 0);
    chk("post-reset alu_a", alu_a_o, 1);
    @(posedge clk_i);
    #1;
    chk("post-reset rsp0_res", rsp0_res_o, 2);
    @(negedge clk_i);
    #1;
    chk("post-reset second grant port1", {req0_ready_o, req1_ready_o}, 2'b01);
    @(negedge clk_i);
    drive(0, 0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
